// File: rtl/hwt_pkg.sv
// Shared types and constants for the hwt truth-table sweeper.
package hwt_pkg;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned TT_W  = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [TT_W-1:0] EXPECTED_DEF = 16'h2888;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/hwt_settle_cnt.sv
// Settle timer: load restarts the count at 0, done flags the last settle cycle.
module hwt_settle_cnt
  import hwt_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] count;

  // done is registered so it rises in the same cycle count reaches LAST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b0;
    end else if (load) begin
      count <= '0;
      done  <= (LAST == '0);
    end else if (en && !done) begin
      count <= count + CNT_W'(1);
      done  <= ((count + CNT_W'(1)) == LAST);
    end
  end

endmodule

// File: rtl/hwt_sweep.sv
// Sweeps all 16 input vectors through an external hwt function and captures
// its truth table, then hands the result off with a valid/ready handshake.
module hwt_sweep
  import hwt_pkg::*;
#(
  parameter int unsigned     SETTLE   = 2,
  parameter logic [TT_W-1:0] EXPECTED = EXPECTED_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            A,
  output logic            B,
  output logic            C,
  output logic            D,
  input  logic            Y,
  output logic            tt_valid,
  input  logic            tt_ready,
  output logic [TT_W-1:0] tt_data,
  output logic            match
);

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_done;
  logic [TT_W-1:0]  tt_next;

  // Y only reaches tt_data through the register below
  always_comb begin
    cnt_load     = ((state == IDLE) && start) || ((state == SAMPLE) && (idx != IDX_LAST));
    cnt_en       = (state == DRIVE);
    tt_next      = tt_data;
    tt_next[idx] = Y;
  end

  hwt_settle_cnt #(
    .SETTLE(SETTLE)
  ) u_settle_cnt (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .en  (cnt_en),
    .done(cnt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      tt_data      <= '0;
      {A, B, C, D} <= IDX_W'(0);
      busy         <= 1'b0;
      tt_valid     <= 1'b0;
      match        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= DRIVE;
            idx          <= '0;
            tt_data      <= '0;
            {A, B, C, D} <= IDX_W'(0);
            busy         <= 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_done) state <= SAMPLE;
        end
        SAMPLE: begin
          tt_data <= tt_next;
          if (idx == IDX_LAST) begin
            state        <= DONE;
            {A, B, C, D} <= IDX_W'(0);
            tt_valid     <= 1'b1;
            match        <= (tt_next == EXPECTED);
          end else begin
            state        <= DRIVE;
            idx          <= idx + IDX_W'(1);
            {A, B, C, D} <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          // start is deliberately ignored here, even on the exit edge
          if (tt_ready) begin
            state    <= IDLE;
            tt_valid <= 1'b0;
            match    <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwt_sweep.sv
// Randomised scoreboard bench for hwt_sweep: three instances (SETTLE 2, 1, 15)
// driving a behavioural hwt model or stubs; a monitor checks results and timing.
module tb_hwt_sweep;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    start, busy, va, vb, vc, vd, y, tt_valid, tt_ready, match;
  logic [15:0]     tt_data [N];
  int              mode    [N];
  logic [15:0]     lut     [N];

  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  int              acc [N];
  bit              on  [N];
  logic [N-1:0]    prev_v;

  typedef struct {
    int          inst;
    logic [15:0] data;
    logic        m;
    int          vcyc;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int settle(int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 15;
  endfunction

  // hwt function as gates: Y = C.D.!(A.B) + A.B.!C.D
  function automatic logic hwt_gate(logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (c & d & ~(a & b)) | (a & b & ~c & d);
  endfunction

  function automatic logic ref_y(int md, logic [15:0] t, logic [3:0] v);
    case (md)
      0:       return hwt_gate(v);
      1:       return 1'b1;
      2:       return v[0];
      default: return t[v];
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    hwt_sweep #(.SETTLE(S)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start[g]),
      .busy    (busy[g]),
      .A       (va[g]),
      .B       (vb[g]),
      .C       (vc[g]),
      .D       (vd[g]),
      .Y       (y[g]),
      .tt_valid(tt_valid[g]),
      .tt_ready(tt_ready[g]),
      .tt_data (tt_data[g]),
      .match   (match[g])
    );
    assign y[g] = ref_y(mode[g], lut[g], {va[g], vb[g], vc[g], vd[g]});
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @cyc %0d", n, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] vec(int i);
    return {va[i], vb[i], vc[i], vd[i]};
  endfunction

  // Monitor: vector order, match qualification, scoreboard pop on tt_valid rise
  always @(negedge clk) begin
    if (rst) begin
      prev_v = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!tt_valid[i]) chk($sformatf("match_qual[%0d]", i), 32'(match[i]), 32'd0);
        if (tt_valid[i])  chk($sformatf("vec_done[%0d]", i), 32'(vec(i)), 32'd0);
        if (on[i]) begin
          int e, l;
          e = cyc - acc[i];
          l = 16 * (settle(i) + 1);
          if (e < l) begin
            chk($sformatf("vec_order[%0d]", i), 32'(vec(i)), 32'(e / (settle(i) + 1)));
            chk($sformatf("busy_sweep[%0d]", i), 32'(busy[i]), 32'd1);
          end
        end
        if (tt_valid[i] && !prev_v[i]) begin
          if (sbq.size() == 0) begin
            chk($sformatf("unexpected_valid[%0d]", i), 32'd1, 32'd0);
          end else begin
            exp_t x;
            x = sbq.pop_front();
            chk("sb_inst", 32'(i), 32'(x.inst));
            chk($sformatf("tt_data[%0d]", i), 32'(tt_data[i]), 32'(x.data));
            chk($sformatf("match[%0d]", i), 32'(match[i]), 32'(x.m));
            chk($sformatf("latency[%0d]", i), 32'(cyc), 32'(x.vcyc));
            chk($sformatf("busy_done[%0d]", i), 32'(busy[i]), 32'd1);
          end
          on[i] = 1'b0;
        end
        prev_v[i] = tt_valid[i];
      end
    end
  end

  task automatic kick(int i, int md);
    logic [15:0] d;
    mode[i] = md;
    if (md == 3) lut[i] = 16'($urandom);
    for (int v = 0; v < 16; v++) d[v] = ref_y(md, lut[i], 4'(v));
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    acc[i]   = cyc;
    on[i]    = 1'b1;
    sbq.push_back('{i, d, (d == 16'h2888), cyc + 16 * (settle(i) + 1)});
  endtask

  task automatic wait_valid(int i);
    for (int k = 0; k < 600; k++) begin
      if (tt_valid[i]) return;
      @(posedge clk); #1;
    end
    chk($sformatf("timeout_valid[%0d]", i), 32'd0, 32'd1);
  endtask

  task automatic release_res(int i);
    tt_ready[i] = 1'b1;
    @(posedge clk); #1;
    tt_ready[i] = 1'b0;
    chk($sformatf("valid_drop[%0d]", i), 32'(tt_valid[i]), 32'd0);
    chk($sformatf("busy_drop[%0d]", i), 32'(busy[i]), 32'd0);
  endtask

  task automatic chk_zero(int i, string tag);
    chk($sformatf("%s_busy[%0d]", tag, i),  32'(busy[i]), 32'd0);
    chk($sformatf("%s_vec[%0d]", tag, i),   32'(vec(i)), 32'd0);
    chk($sformatf("%s_valid[%0d]", tag, i), 32'(tt_valid[i]), 32'd0);
    chk($sformatf("%s_match[%0d]", tag, i), 32'(match[i]), 32'd0);
    chk($sformatf("%s_data[%0d]", tag, i),  32'(tt_data[i]), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = '0;
    tt_ready = '0;
    prev_v = '0;
    for (int i = 0; i < N; i++) begin
      mode[i] = 0; lut[i] = '0; acc[i] = 0; on[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk_zero(i, "reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("idle_no_start[%0d]", i), 32'(busy[i]), 32'd0);

    // Golden hwt and the two stubs
    kick(0, 0); wait_valid(0); release_res(0);
    kick(0, 1); wait_valid(0); release_res(0);
    kick(0, 2); wait_valid(0); release_res(0);

    // Hold in DONE with ready low; start pulses must be ignored
    kick(0, 0); wait_valid(0);
    for (int k = 0; k < 10; k++) begin
      chk("hold_valid", 32'(tt_valid[0]), 32'd1);
      chk("hold_data", 32'(tt_data[0]), 32'h2888);
      chk("hold_busy", 32'(busy[0]), 32'd1);
      start[0] = (k % 3 == 2);
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    release_res(0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_hold_idle", 32'(busy[0]), 32'd0);
    end

    // Asynchronous reset while vector 7 is being driven
    kick(0, 0);
    begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
        if (vec(0) == 4'd7) begin found = 1'b1; break; end
        @(posedge clk); #1;
      end
      chk("reach_idx7", 32'(found), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk_zero(0, "async_rst");
    void'(sbq.pop_back());
    on[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_idle", 32'(busy[0]), 32'd0);
    end
    kick(0, 0); wait_valid(0); release_res(0);

    // SETTLE = 1 and SETTLE = 15 latency and vector order
    kick(1, 0); wait_valid(1); release_res(1);
    kick(2, 0); wait_valid(2); release_res(2);

    // start and tt_ready together in DONE: handshake only, no new sweep
    kick(0, 0); wait_valid(0);
    start[0] = 1'b1;
    tt_ready[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    tt_ready[0] = 1'b0;
    chk("both_valid", 32'(tt_valid[0]), 32'd0);
    chk("both_busy", 32'(busy[0]), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("both_no_sweep", 32'(busy[0]), 32'd0);
    end

    // Randomised sweeps: random instance, Y source and ready delay
    repeat (6) begin
      int i, md;
      i  = $urandom_range(0, 1);
      md = $urandom_range(0, 3);
      kick(i, md);
      wait_valid(i);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      release_res(i);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
